// File: rtl/note_acceptor.sv
// note_acceptor: banknote validator FSM feeding a downstream note buffer, with saturating totals.
// Define NOTE_FIFO_EN for a 4-entry note FIFO; otherwise the buffer is a single holding register.
module note_acceptor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        note_vld,
    input  logic [2:0]  note_code,
    input  logic        ia_rdy,
    output logic [9:0]  ia,
    output logic        ia_vld,
    output logic        reject,
    output logic        busy,
    output logic [13:0] total,
    output logic [7:0]  note_cnt
);
`ifdef NOTE_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, ACCEPT, REJECT} state_t;

    state_t        r_state, w_next;
    logic [2:0]    r_code;
    logic [9:0]    r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_rd, r_wr;
    logic [2:0]    r_cnt;
    logic [13:0]   r_total;
    logic [7:0]    r_note_cnt;
    logic [9:0]    w_val;
    logic [14:0]   w_sum;
    logic          w_full, w_push, w_pop;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        w_val = '0;
        case (r_code)
            3'd1:    w_val = 10'd5;
            3'd2:    w_val = 10'd10;
            3'd3:    w_val = 10'd20;
            3'd4:    w_val = 10'd50;
            3'd5:    w_val = 10'd100;
            3'd6:    w_val = 10'd500;
            3'd7:    w_val = 10'd1000;
            default: w_val = '0;
        endcase
    end

    // Fullness is the registered count, so a pop on the CHECK edge cannot help that note.
    assign w_full = (r_cnt == 3'(DEPTH));
    assign w_push = (r_state == ACCEPT);
    assign w_pop  = ia_vld && ia_rdy;
    assign w_sum  = {1'b0, r_total} + 15'(w_val);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = note_vld ? CHECK : IDLE;
            CHECK:   w_next = (w_val != '0 && en && !w_full) ? ACCEPT : REJECT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= '0;
        end else begin
            r_state <= clr ? IDLE : w_next;
            if (!clr && r_state == IDLE && note_vld)
                r_code <= note_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wr <= f_inc(r_wr);
            if (w_pop)
                r_rd <= f_inc(r_rd);
            r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clr)
            r_mem[r_wr] <= w_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total    <= '0;
            r_note_cnt <= '0;
        end else if (clr) begin
            r_total    <= '0;
            r_note_cnt <= '0;
        end else if (w_push) begin
            r_total    <= w_sum[14] ? 14'h3FFF : w_sum[13:0];
            r_note_cnt <= (&r_note_cnt) ? r_note_cnt : r_note_cnt + 8'd1;
        end
    end

    assign ia_vld   = (r_cnt != '0);
    assign ia       = ia_vld ? r_mem[r_rd] : '0;
    assign reject   = (r_state == REJECT);
    assign busy     = (r_state != IDLE);
    assign total    = r_total;
    assign note_cnt = r_note_cnt;
endmodule
